// File: rtl/seg7_pkg.sv
// Shared segment glyphs (active-low, bit6 = a) and polarity helper for the seg7 scan driver.
// Hex glyphs are only decoded when SEG7_HEX_DIGITS_EN is defined.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    function automatic logic [6:0] seg_polarity(input logic [6:0] seg_al, input logic active_low);
        return active_low ? seg_al : ~seg_al;
    endfunction

endpackage

// File: rtl/seg7_glyph_dec.sv
// 4-bit code to active-low 7-segment pattern. Codes 10-15 blank unless
// SEG7_HEX_DIGITS_EN is defined, in which case they show A,b,C,d,E,F.
module seg7_glyph_dec
    import seg7_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg_al
);

    always_comb begin
        o_seg_al = SEG_BLANK;
        case (i_code)
            4'd0: o_seg_al = SEG_0;
            4'd1: o_seg_al = SEG_1;
            4'd2: o_seg_al = SEG_2;
            4'd3: o_seg_al = SEG_3;
            4'd4: o_seg_al = SEG_4;
            4'd5: o_seg_al = SEG_5;
            4'd6: o_seg_al = SEG_6;
            4'd7: o_seg_al = SEG_7;
            4'd8: o_seg_al = SEG_8;
            4'd9: o_seg_al = SEG_9;
`ifdef SEG7_HEX_DIGITS_EN
            4'hA: o_seg_al = SEG_A;
            4'hB: o_seg_al = SEG_B;
            4'hC: o_seg_al = SEG_C;
            4'hD: o_seg_al = SEG_D;
            4'hE: o_seg_al = SEG_E;
            4'hF: o_seg_al = SEG_F;
`endif
            default: o_seg_al = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment driver: latched BCD word, refresh prescaler, ghosting guard,
// leading-zero blanking. SEG7_HEX_DIGITS_EN enables hex glyphs plus a "word valid" flag.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD          = 64,
    parameter int LZ_BLANK       = 1,
    parameter int ACTIVE_LOW_SEG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] valores,
    input  logic                  en,
    output logic [6:0]            saidas,
    output logic [N_DIGITS-1:0]   anodos,
    output logic                  busy_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [6:0] SEG_OFF = seg_polarity(SEG_BLANK, ACTIVE_LOW_SEG != 0);

    logic [4*N_DIGITS-1:0] r_word;
    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    logic [6:0]            r_saidas;
    logic [N_DIGITS-1:0]   r_anodos;
    logic                  r_busy;

    logic [4*N_DIGITS-1:0] w_word_nxt;
    logic [PW-1:0]         w_presc_nxt;
    logic [IW-1:0]         w_idx_nxt;
    logic                  w_wrap_p;
    logic                  w_wrap_i;
    logic [3:0]            w_digit [N_DIGITS];
    logic [N_DIGITS-1:0]   w_lz;
    logic                  w_zero_run;
    logic [3:0]            w_code;
    logic                  w_blank;
    logic [N_DIGITS-1:0]   w_an;
    logic [6:0]            w_glyph;
    logic [6:0]            w_seg_al;
    logic [6:0]            w_seg;

`ifdef SEG7_HEX_DIGITS_EN
    // 4'hF is a real glyph here, so an explicit flag keeps the display dark until the first load.
    logic r_valid;
    always_ff @(posedge clk) begin
        if (rst) r_valid <= 1'b0;
        else if (load) r_valid <= 1'b1;
    end
`endif

    // Outputs are registered from next-state values so the latch, index and pins move together.
    always_comb begin
        w_word_nxt  = load ? valores : r_word;
        w_wrap_p    = (r_presc == PW'(REFRESH_DIV - 1));
        w_wrap_i    = (r_idx == IW'(N_DIGITS - 1));
        w_presc_nxt = r_presc;
        w_idx_nxt   = r_idx;
        if (en) begin
            if (w_wrap_p) begin
                w_presc_nxt = '0;
                w_idx_nxt   = w_wrap_i ? '0 : r_idx + IW'(1);
            end else begin
                w_presc_nxt = r_presc + PW'(1);
            end
        end

        w_digit    = '{default: '0};
        w_lz       = '0;
        w_zero_run = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            w_digit[k] = w_word_nxt[4*k +: 4];
            w_zero_run = w_zero_run & (w_digit[k] == 4'd0);
            w_lz[k]    = (LZ_BLANK != 0) && (k != 0) && w_zero_run;
        end

        w_code  = w_digit[w_idx_nxt];
        w_blank = w_lz[w_idx_nxt];
`ifdef SEG7_HEX_DIGITS_EN
        w_blank = w_blank | ~(r_valid | load);
`endif

        w_an = '1;
        if (int'(w_presc_nxt) >= GUARD) w_an[w_idx_nxt] = 1'b0;
    end

    seg7_glyph_dec u_glyph (
        .i_code   (w_code),
        .o_seg_al (w_glyph)
    );

    assign w_seg_al = w_blank ? SEG_BLANK : w_glyph;
    assign w_seg    = seg_polarity(w_seg_al, ACTIVE_LOW_SEG != 0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word   <= {N_DIGITS{BLANK_CODE}};
            r_presc  <= '0;
            r_idx    <= '0;
            r_anodos <= '1;
            r_saidas <= SEG_OFF;
            r_busy   <= 1'b0;
        end else begin
            if (load) r_word <= valores;
            r_presc <= w_presc_nxt;
            r_idx   <= w_idx_nxt;
            if (en) begin
                r_anodos <= w_an;
                r_saidas <= w_seg;
                r_busy   <= w_wrap_p & w_wrap_i;
            end else begin
                r_anodos <= '1;
                r_saidas <= SEG_OFF;
                r_busy   <= 1'b0;
            end
        end
    end

    assign saidas    = r_saidas;
    assign anodos    = r_anodos;
    assign busy_tick = r_busy;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (N=4, DIV=4, GUARD=1); hex expectations follow SEG7_HEX_DIGITS_EN.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        en = 1'b0;
    logic [15:0] valores = 16'h0000;
    logic [6:0]  saidas;
    logic [3:0]  anodos;
    logic        busy_tick;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .N_DIGITS       (4),
        .REFRESH_DIV    (4),
        .GUARD          (1),
        .LZ_BLANK       (1),
        .ACTIVE_LOW_SEG (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .valores   (valores),
        .en        (en),
        .saidas    (saidas),
        .anodos    (anodos),
        .busy_tick (busy_tick)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       bt;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    localparam logic [6:0] G0 = 7'h01, G1 = 7'h4F, G2 = 7'h12, G3 = 7'h06, G4 = 7'h4C;
    localparam logic [6:0] G5 = 7'h24, G6 = 7'h20, G7 = 7'h0F, G8 = 7'h00, BL = 7'h7F;
`ifdef SEG7_HEX_DIGITS_EN
    localparam logic [6:0] XA = 7'h08, XB = 7'h60, XC = 7'h31, XD = 7'h42;
`else
    localparam logic [6:0] XA = BL, XB = BL, XC = BL, XD = BL;
`endif

    function automatic logic [3:0] an_for(input int d);
        logic [3:0] a;
        a = 4'hF;
        a[d] = 1'b0;
        return a;
    endfunction

    task automatic step(input logic r, input logic ld, input logic [15:0] v, input logic e,
                        input logic [3:0] an, input logic [6:0] seg, input logic bt);
        exp_t x;
        @(negedge clk);
        rst = r; load = ld; valores = v; en = e;
        x.an = an; x.seg = seg; x.bt = bt; x.id = step_id;
        sb.push_back(x);
        step_id++;
    endtask

    task automatic active(input int d, input logic [6:0] seg, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h9999, 1'b1, an_for(d), seg, 1'b0);
    endtask

    task automatic slot(input int d, input logic [6:0] seg, input logic bt,
                        input logic ld, input logic [15:0] v);
        step(1'b0, ld, v, 1'b1, 4'hF, seg, bt);
        active(d, seg, 3);
    endtask

    // Monitor: every clock presents a fresh output triple.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (anodos !== e.an) begin
                    errors++;
                    $display("FAIL anodos step %0d: got %b, expected %b", e.id, anodos, e.an);
                end
                checks++;
                if (saidas !== e.seg) begin
                    errors++;
                    $display("FAIL saidas step %0d: got %b, expected %b", e.id, saidas, e.seg);
                end
                checks++;
                if (busy_tick !== e.bt) begin
                    errors++;
                    $display("FAIL busy_tick step %0d: got %b, expected %b", e.id, busy_tick, e.bt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: stimulus did not complete, %0d entries pending", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset, then free-run with nothing loaded: dark segments, first wrap 16 cycles in.
        step(1'b1, 1'b0, 16'h0000, 1'b1, 4'hF, BL, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 4'hF, BL, 1'b0);
        active(0, BL, 3);
        slot(1, BL, 1'b0, 1'b0, 16'h9999);
        slot(2, BL, 1'b0, 1'b0, 16'h9999);
        slot(3, BL, 1'b0, 1'b0, 16'h9999);

        // Load on the wrap cycle: new word shows in the slot that starts on that edge.
        slot(0, G4, 1'b1, 1'b1, 16'h1234);
        slot(1, G3, 1'b0, 1'b0, 16'h9999);
        slot(2, G2, 1'b0, 1'b0, 16'h9999);
        slot(3, G1, 1'b0, 1'b0, 16'h9999);

        slot(0, G7, 1'b1, 1'b1, 16'h0007);
        slot(1, BL, 1'b0, 1'b0, 16'h9999);
        slot(2, BL, 1'b0, 1'b0, 16'h9999);
        slot(3, BL, 1'b0, 1'b0, 16'h9999);

        slot(0, G0, 1'b1, 1'b1, 16'h0000);
        slot(1, BL, 1'b0, 1'b0, 16'h9999);
        slot(2, BL, 1'b0, 1'b0, 16'h9999);
        slot(3, BL, 1'b0, 1'b0, 16'h9999);

        // Pause mid-slot on digit 2, then resume from the held prescaler.
        slot(0, G8, 1'b1, 1'b1, 16'h5678);
        slot(1, G7, 1'b0, 1'b0, 16'h9999);
        step(1'b0, 1'b0, 16'h9999, 1'b1, 4'hF, G6, 1'b0);
        active(2, G6, 1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h9999, 1'b0, 4'hF, BL, 1'b0);
        active(2, G6, 2);
        slot(3, G5, 1'b0, 1'b0, 16'h9999);

        slot(0, XD, 1'b1, 1'b1, 16'hABCD);
        slot(1, XC, 1'b0, 1'b0, 16'h9999);
        slot(2, XB, 1'b0, 1'b0, 16'h9999);
        slot(3, XA, 1'b0, 1'b0, 16'h9999);

        // Interior zero stays lit because a non-zero digit sits above it.
        slot(0, G0, 1'b1, 1'b1, 16'h1020);
        slot(1, G2, 1'b0, 1'b0, 16'h9999);
        slot(2, G0, 1'b0, 1'b0, 16'h9999);
        slot(3, G1, 1'b0, 1'b0, 16'h9999);

        // Reset mid-slot on digit 1 clears the word and the scan position.
        slot(0, G0, 1'b1, 1'b0, 16'h9999);
        step(1'b0, 1'b0, 16'h9999, 1'b1, 4'hF, G2, 1'b0);
        active(1, G2, 1);
        step(1'b1, 1'b0, 16'h9999, 1'b1, 4'hF, BL, 1'b0);
        active(0, BL, 3);
        step(1'b0, 1'b0, 16'h9999, 1'b1, 4'hF, BL, 1'b0);

        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
